// File: rtl/gmii_frame_merger_if.sv
// Ingress/egress GMII bundle for gmii_frame_merger.
// The master drives the ingress ports; the slave is the merger itself.
interface gmii_frame_merger_if #(
  parameter int unsigned N_PORTS = 3
);
  logic [N_PORTS*8-1:0] in_rxd;
  logic [N_PORTS-1:0]   in_rx_dv;
  logic [N_PORTS-1:0]   in_rx_er;
  logic [7:0]           out_txd;
  logic                 out_tx_en;
  logic                 out_tx_er;
  logic [N_PORTS-1:0]   drop_pulse;

  modport master (
    output in_rxd, in_rx_dv, in_rx_er,
    input  out_txd, out_tx_en, out_tx_er, drop_pulse
  );

  modport slave (
    input  in_rxd, in_rx_dv, in_rx_er,
    output out_txd, out_tx_en, out_tx_er, drop_pulse
  );
endinterface

// File: rtl/gmii_frame_merger.sv
// N-port store-and-forward GMII merger with round-robin frame arbitration and egress IFG.
// Optional per-port counters are enabled by defining GMII_MERGER_STATS_EN.
module gmii_frame_merger #(
  parameter int unsigned N_PORTS    = 3,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned IFG_CYCLES = 12
) (
  input logic               gmii_clocks,
  input logic               rst,
  gmii_frame_merger_if.slave bus
`ifdef GMII_MERGER_STATS_EN
  ,
  output logic [N_PORTS*32-1:0] stat_frames,
  output logic [N_PORTS*16-1:0] stat_drops
`endif
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned PSEL_W = $clog2(N_PORTS);
  localparam int unsigned CW     = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {ST_GAP, ST_ARB, ST_SEND} eg_state_e;
  typedef enum logic {ING_ACTIVE, ING_SKIP} ing_state_e;

  // Each entry is {er, last, data}
  logic [9:0] mem [N_PORTS][DEPTH];

  logic [N_PORTS-1:0] dv_r_q, er_r_q, commit_q, drop_q;
  logic [7:0]         d_r_q  [N_PORTS];
  ing_state_e         ing_q  [N_PORTS];
  logic [PW-1:0]      wp_q   [N_PORTS];
  logic [PW-1:0]      cp_q   [N_PORTS];
  logic [PW-1:0]      rp_q   [N_PORTS];
  logic [PW-1:0]      fcnt_q [N_PORTS];
  logic [N_PORTS-1:0] full, wr_en, ovf, deq;

  eg_state_e         st_q, st_d;
  logic [PSEL_W-1:0] rr_q, rr_d, gnt_q, gnt_d, sel, rd_port;
  logic [PW-1:0]     raddr_q, raddr_d, rd_addr;
  logic [CW-1:0]     gap_q, gap_d;
  logic [9:0]        rdata_q;
  logic [7:0]        txd_q, txd_d;
  logic              en_q, en_d, er_q, er_d, rd_en, found;
  int unsigned       idx;

  always_comb begin
    full  = '0;
    wr_en = '0;
    ovf   = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      full[p]  = (wp_q[p][AW] != rp_q[p][AW]) && (wp_q[p][AW-1:0] == rp_q[p][AW-1:0]);
      wr_en[p] = dv_r_q[p] && (ing_q[p] == ING_ACTIVE) && !full[p];
      ovf[p]   = dv_r_q[p] && (ing_q[p] == ING_ACTIVE) && full[p];
    end
  end

  // Ingress registers one cycle so the current dv tells whether the stored byte is last
  always_ff @(posedge gmii_clocks) begin
    if (rst) begin
      dv_r_q   <= '0;
      er_r_q   <= '0;
      commit_q <= '0;
      drop_q   <= '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        d_r_q[p]  <= '0;
        ing_q[p]  <= ING_SKIP;
        wp_q[p]   <= '0;
        cp_q[p]   <= '0;
        rp_q[p]   <= '0;
        fcnt_q[p] <= '0;
      end
    end else begin
      dv_r_q   <= bus.in_rx_dv;
      er_r_q   <= bus.in_rx_er;
      drop_q   <= ovf;
      commit_q <= wr_en & ~bus.in_rx_dv;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        d_r_q[p] <= bus.in_rxd[8*p +: 8];
        if (ovf[p]) begin
          wp_q[p]  <= cp_q[p];
          ing_q[p] <= bus.in_rx_dv[p] ? ING_SKIP : ING_ACTIVE;
        end else begin
          if (wr_en[p]) wp_q[p] <= wp_q[p] + PW'(1);
          if (ing_q[p] == ING_SKIP && !bus.in_rx_dv[p]) ing_q[p] <= ING_ACTIVE;
        end
        if (commit_q[p]) cp_q[p] <= wp_q[p];
        if (deq[p]) rp_q[p] <= raddr_q;
        if (commit_q[p] && !deq[p])      fcnt_q[p] <= fcnt_q[p] + PW'(1);
        else if (!commit_q[p] && deq[p]) fcnt_q[p] <= fcnt_q[p] - PW'(1);
      end
    end
  end

  always_ff @(posedge gmii_clocks) begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (wr_en[p]) mem[p][wp_q[p][AW-1:0]] <= {er_r_q[p], ~bus.in_rx_dv[p], d_r_q[p]};
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      idx = (32'(rr_q) + i) % N_PORTS;
      if (!found && fcnt_q[idx] != '0) begin
        found = 1'b1;
        sel   = PSEL_W'(idx);
      end
    end
  end

  // ARB and the RAM prefetch cost two idle cycles, so GAP exits two counts early
  always_comb begin
    st_d    = st_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    raddr_d = raddr_q;
    gap_d   = gap_q;
    rd_en   = 1'b0;
    rd_port = gnt_q;
    rd_addr = raddr_q;
    deq     = '0;
    txd_d   = '0;
    en_d    = 1'b0;
    er_d    = 1'b0;
    case (st_q)
      ST_GAP: begin
        if (gap_q < CW'(IFG_CYCLES)) gap_d = gap_q + CW'(1);
        if (32'(gap_q) + 32'd2 >= IFG_CYCLES) st_d = ST_ARB;
      end
      ST_ARB: begin
        if (found) begin
          gnt_d   = sel;
          rd_en   = 1'b1;
          rd_port = sel;
          rd_addr = rp_q[sel];
          raddr_d = rp_q[sel] + PW'(1);
          rr_d    = (32'(sel) == N_PORTS - 1) ? '0 : sel + PSEL_W'(1);
          st_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        txd_d   = rdata_q[7:0];
        en_d    = 1'b1;
        er_d    = rdata_q[9];
        rd_en   = 1'b1;
        raddr_d = raddr_q + PW'(1);
        if (rdata_q[8]) begin
          deq[gnt_q] = 1'b1;
          gap_d      = '0;
          st_d       = ST_GAP;
        end
      end
      default: st_d = ST_GAP;
    endcase
  end

  always_ff @(posedge gmii_clocks) begin
    if (rst) begin
      st_q    <= ST_GAP;
      gap_q   <= CW'(IFG_CYCLES);
      rr_q    <= '0;
      gnt_q   <= '0;
      raddr_q <= '0;
      rdata_q <= '0;
      txd_q   <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      raddr_q <= raddr_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
      if (rd_en) rdata_q <= mem[rd_port][rd_addr[AW-1:0]];
    end
  end

  assign bus.out_txd    = txd_q;
  assign bus.out_tx_en  = en_q;
  assign bus.out_tx_er  = er_q;
  assign bus.drop_pulse = drop_q;

`ifdef GMII_MERGER_STATS_EN
  logic [31:0] sf_q [N_PORTS];
  logic [15:0] sd_q [N_PORTS];

  always_ff @(posedge gmii_clocks) begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (rst) begin
        sf_q[p] <= '0;
        sd_q[p] <= '0;
      end else begin
        if (deq[p] && sf_q[p] != '1) sf_q[p] <= sf_q[p] + 32'd1;
        if (ovf[p] && sd_q[p] != '1) sd_q[p] <= sd_q[p] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_frames = '0;
    stat_drops  = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      stat_frames[32*p +: 32] = sf_q[p];
      stat_drops[16*p +: 16]  = sd_q[p];
    end
  end
`endif
endmodule

// File: tb/tb_gmii_frame_merger.sv
// Directed bench for gmii_frame_merger: table-driven single frames plus
// arbitration/IFG, overflow, error replay and reset-during-send sequences.
module tb_gmii_frame_merger;
  localparam int unsigned NP    = 3;
  localparam int unsigned DEPTH = 2048;
  localparam int unsigned IFG   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  gmii_frame_merger_if #(.N_PORTS(NP)) bus ();

`ifdef GMII_MERGER_STATS_EN
  logic [NP*32-1:0] stat_frames;
  logic [NP*16-1:0] stat_drops;
`endif

  gmii_frame_merger #(.N_PORTS(NP), .DEPTH(DEPTH), .IFG_CYCLES(IFG)) dut (
    .gmii_clocks(clk),
    .rst        (rst),
    .bus        (bus)
`ifdef GMII_MERGER_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_drops (stat_drops)
`endif
  );

  typedef struct {
    int     len;
    int     first;
    int     last;
    int     er_cnt;
    int     er_idx;
    int     bad;
    longint rise;
    longint fin;
  } frame_t;

  typedef struct {
    int port;
    int len;
    int base;
    int erb;
    int exp_len;
    int exp_first;
    int exp_last;
    int exp_er_cnt;
    int exp_er_idx;
  } vec_t;

  int       checks = 0;
  int       errors = 0;
  longint   cyc = 0;
  longint   first_cyc, fall_cyc;
  frame_t   frames[$];
  frame_t   cur;
  bit       in_fr = 1'b0;
  logic [7:0] prevb;
  int       drop_cnt [NP];
  longint   drop_cyc [NP];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_tx_en) begin
      if (!in_fr) begin
        in_fr      = 1'b1;
        cur.len    = 0;
        cur.first  = int'(bus.out_txd);
        cur.rise   = cyc;
        cur.er_cnt = 0;
        cur.er_idx = -1;
        cur.bad    = 0;
      end else if (bus.out_txd != 8'(prevb + 8'd1)) begin
        cur.bad++;
      end
      prevb = bus.out_txd;
      if (bus.out_tx_er) begin
        cur.er_cnt++;
        cur.er_idx = cur.len;
      end
      cur.last = int'(bus.out_txd);
      cur.len++;
      cur.fin = cyc;
    end else if (in_fr) begin
      in_fr = 1'b0;
      frames.push_back(cur);
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.drop_pulse[p]) begin
        drop_cnt[p]++;
        drop_cyc[p] = cyc;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [NP-1:0] mask, input int len, input int base,
                      input int step, input int erport, input int erb);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (k == 0) first_cyc = cyc + 1;
      for (int p = 0; p < NP; p++) begin
        if (mask[p]) begin
          bus.in_rxd[8*p +: 8] = 8'(base + step * p + k);
          bus.in_rx_dv[p]      = 1'b1;
          bus.in_rx_er[p]      = (p == erport) && (k == erb);
        end
      end
    end
    @(posedge clk); #1;
    bus.in_rx_dv = '0;
    bus.in_rx_er = '0;
    bus.in_rxd   = '0;
    fall_cyc     = cyc + 1;
  endtask

  task automatic wait_frames(input int n, input int budget, input string nm);
    int t = 0;
    while (frames.size() < n && t < budget) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_arrived"}, longint'(frames.size() >= n), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk); #1;
    chk({nm, "_tx_en"}, longint'(bus.out_tx_en), 0);
    chk({nm, "_txd"}, longint'(bus.out_txd), 0);
    chk({nm, "_tx_er"}, longint'(bus.out_tx_er), 0);
    chk({nm, "_drop"}, longint'(bus.drop_pulse), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    frame_t f;
    logic [NP-1:0] m;
    int n0, n1, d0, t;

    vecs[0] = '{0,  64, 'h00, -1,  64, 'h00, 'h3F, 0, -1};
    vecs[1] = '{1,  60, 'h80, -1,  60, 'h80, 'hBB, 0, -1};
    vecs[2] = '{2, 100, 'h10, 10, 100, 'h10, 'h73, 1, 10};
    vecs[3] = '{0,   1, 'hAA, -1,   1, 'hAA, 'hAA, 0, -1};
    vecs[4] = '{1,   2, 'hFE, -1,   2, 'hFE, 'hFF, 0, -1};
    vecs[5] = '{2,   3, 'hFF,  2,   3, 'hFF, 'h01, 1,  2};

    bus.in_rxd   = '0;
    bus.in_rx_dv = '0;
    bus.in_rx_er = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    foreach (vecs[i]) begin
      n0 = frames.size();
      m = '0;
      m[vecs[i].port] = 1'b1;
      send(m, vecs[i].len, vecs[i].base, 0, vecs[i].port, vecs[i].erb);
      wait_frames(n0 + 1, 600, $sformatf("vec%0d", i));
      if (frames.size() > n0) begin
        f = frames[n0];
        chk($sformatf("vec%0d_len", i), f.len, vecs[i].exp_len);
        chk($sformatf("vec%0d_first", i), f.first, vecs[i].exp_first);
        chk($sformatf("vec%0d_last", i), f.last, vecs[i].exp_last);
        chk($sformatf("vec%0d_er_cnt", i), f.er_cnt, vecs[i].exp_er_cnt);
        chk($sformatf("vec%0d_er_idx", i), f.er_idx, vecs[i].exp_er_idx);
        chk($sformatf("vec%0d_seq", i), f.bad, 0);
        chk($sformatf("vec%0d_latency", i), f.rise - fall_cyc, 3);
      end
      repeat (20) @(posedge clk);
    end

    // three ports finishing together: order 0,1,2 with exactly IFG idle cycles
    do_reset();
    check_reset_outputs("reset2");
    n0 = frames.size();
    send(3'b111, 60, 0, 64, -1, -1);
    wait_frames(n0 + 3, 1000, "rr3");
    if (frames.size() >= n0 + 3) begin
      chk("rr_latency", frames[n0].rise - fall_cyc, 3);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rr_first%0d", i), frames[n0+i].first, 64 * i);
        chk($sformatf("rr_len%0d", i), frames[n0+i].len, 60);
      end
      chk("rr_gap01", frames[n0+1].rise - frames[n0].fin - 1, IFG);
      chk("rr_gap12", frames[n0+2].rise - frames[n0+1].fin - 1, IFG);
    end
    repeat (20) @(posedge clk);
    n0 = frames.size();
    send(3'b101, 20, 'h10, 'h40, -1, -1);
    wait_frames(n0 + 2, 600, "rr2");
    if (frames.size() >= n0 + 2) begin
      chk("rr_next_first", frames[n0].first, 'h10);
      chk("rr_next_second", frames[n0+1].first, 'h90);
      chk("rr_next_gap", frames[n0+1].rise - frames[n0].fin - 1, IFG);
    end
    repeat (20) @(posedge clk);

    // oversized frame on port 1 is dropped at byte 2049, the next one forwarded
    n0 = frames.size();
    d0 = drop_cnt[1];
    send(3'b010, 2100, 0, 0, -1, -1);
    repeat (50) @(posedge clk);
    chk("ovf_drop_count", drop_cnt[1], d0 + 1);
    chk("ovf_drop_byte", drop_cyc[1] - first_cyc, 2049);
    chk("ovf_nothing_sent", frames.size(), n0);
    send(3'b010, 60, 'h20, 0, -1, -1);
    wait_frames(n0 + 1, 600, "ovf_next");
    if (frames.size() > n0) begin
      chk("ovf_next_len", frames[n0].len, 60);
      chk("ovf_next_first", frames[n0].first, 'h20);
      chk("ovf_next_last", frames[n0].last, 'h5B);
    end
    chk("ovf_single_pulse", drop_cnt[1], d0 + 1);
    chk("no_drop_port0", drop_cnt[0], 0);
    chk("no_drop_port2", drop_cnt[2], 0);
    repeat (20) @(posedge clk);

    // reset in the middle of a 200-byte egress frame
    send(3'b001, 200, 0, 0, -1, -1);
    t = 0;
    while (!(in_fr && cur.len == 30) && t < 800) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_send_reached", longint'(in_fr && cur.len == 30), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_send_tx_en", longint'(bus.out_tx_en), 0);
    chk("rst_send_txd", longint'(bus.out_txd), 0);
    if (frames.size() > 0) chk("rst_send_trunc_len", frames[frames.size()-1].len, 30);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n1 = frames.size();
    repeat (300) @(posedge clk);
    chk("rst_send_silent", frames.size(), n1);
    chk("rst_send_idle", longint'(in_fr), 0);
    send(3'b100, 40, 'h33, 0, -1, -1);
    wait_frames(n1 + 1, 600, "rst_send_new");
    if (frames.size() > n1) begin
      chk("rst_new_len", frames[n1].len, 40);
      chk("rst_new_first", frames[n1].first, 'h33);
      chk("rst_new_last", frames[n1].last, 'h5A);
      chk("rst_new_latency", frames[n1].rise - fall_cyc, 3);
    end

`ifdef GMII_MERGER_STATS_EN
    do_reset();
    @(negedge clk); #1;
    chk("stat_frames_reset", longint'(stat_frames[31:0]), 0);
    chk("stat_drops_reset", longint'(stat_drops[15:0]), 0);
    for (int i = 0; i < 5; i++) begin
      n0 = frames.size();
      send(3'b001, 20, 8 * i, 0, -1, -1);
      wait_frames(n0 + 1, 600, $sformatf("stat_fr%0d", i));
      repeat (20) @(posedge clk);
    end
    send(3'b001, 2100, 0, 0, -1, -1);
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    chk("stat_frames0", longint'(stat_frames[31:0]), 5);
    chk("stat_drops0", longint'(stat_drops[15:0]), 1);
    chk("stat_frames1", longint'(stat_frames[63:32]), 0);
    chk("stat_drops1", longint'(stat_drops[31:16]), 0);
`endif

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog actual timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
